// File: rtl/operand_entry.sv
// Keypad operand accumulator: gathers decimal digits into OPERANDS operands (binary and
// packed BCD) separated by operator keys, then holds the expression for a ready/ack consumer.
module operand_entry #(
  parameter int DIGITS   = 4,
  parameter int OPERANDS = 2,
  parameter int BIN_W    = 14
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            digit_valid,
  input  logic [3:0]                      digit,
  input  logic                            op_valid,
  input  logic [1:0]                      op_code,
  input  logic                            eq_valid,
  input  logic                            clear_entry,
  input  logic                            clear_all,
  input  logic                            result_ack,
  output logic [OPERANDS*BIN_W-1:0]       operands_bin,
  output logic [OPERANDS*4*DIGITS-1:0]    operands_bcd,
  output logic [2*(OPERANDS-1)-1:0]       op_codes,
  output logic [((OPERANDS > 2) ? $clog2(OPERANDS) : 1)-1:0] cur_index,
  output logic [$clog2(DIGITS+1)-1:0]     digit_count,
  output logic [$clog2(OPERANDS+1)-1:0]   operand_count,
  output logic                            ready,
  output logic                            reject,
  output logic                            state_dbg
);

  localparam int CIW  = (OPERANDS > 2) ? $clog2(OPERANDS) : 1;
  localparam int DCW  = $clog2(DIGITS+1);
  localparam int OCW  = $clog2(OPERANDS+1);
  localparam int BCDW = 4*DIGITS;
  localparam int EXTW = BIN_W + 4;
  localparam logic [CIW-1:0] LAST_IDX = CIW'(OPERANDS-1);
  localparam logic [DCW-1:0] MAX_DC   = DCW'(DIGITS);

  typedef enum logic {S_ENTRY = 1'b0, S_READY = 1'b1} state_t;

  // Handshake: ready stays high with every output frozen until result_ack (or clear_all)
  // is sampled; the cleared expression is visible on the following cycle.
  state_t            r_state;
  state_t            w_state_nxt;
  logic [BIN_W-1:0]  r_bin [OPERANDS];
  logic [BCDW-1:0]   r_bcd [OPERANDS];
  logic [1:0]        r_opc [OPERANDS-1];
  logic [CIW-1:0]    r_cur;
  logic [DCW-1:0]    r_dc;
  logic [OCW-1:0]    r_opcnt;
  logic              r_reject;

  logic              w_clear;
  logic              w_ready_key;
  logic [EXTW-1:0]   w_bin_ext;
  logic [BIN_W-1:0]  w_bin_nxt;
  logic [BCDW-1:0]   w_bcd_nxt;
  logic              w_digit_bad;
  logic              w_lead_zero;

  assign w_clear     = clear_all | ((r_state == S_READY) & result_ack);
  assign w_ready_key = clear_entry | eq_valid | op_valid | digit_valid;
  assign w_bin_ext   = EXTW'(r_bin[r_cur]) * EXTW'(10) + EXTW'(digit);
  assign w_bin_nxt   = w_bin_ext[BIN_W-1:0];
  assign w_bcd_nxt   = (r_bcd[r_cur] << 4) | BCDW'(digit);
  assign w_digit_bad = (digit > 4'd9) || (r_dc == MAX_DC);
  assign w_lead_zero = (digit == 4'd0) && (r_dc == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_ENTRY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_clear)
      w_state_nxt = S_ENTRY;
    else if ((r_state == S_ENTRY) && !clear_entry && eq_valid)
      w_state_nxt = S_READY;
  end

  always_comb begin
    ready         = (r_state == S_READY);
    state_dbg     = r_state;
    reject        = r_reject;
    cur_index     = r_cur;
    digit_count   = r_dc;
    operand_count = r_opcnt;
    operands_bin  = '0;
    operands_bcd  = '0;
    op_codes      = '0;
    for (int k = 0; k < OPERANDS; k++) begin
      operands_bin[k*BIN_W +: BIN_W] = r_bin[k];
      operands_bcd[k*BCDW +: BCDW]   = r_bcd[k];
    end
    for (int k = 0; k < OPERANDS-1; k++)
      op_codes[2*k +: 2] = r_opc[k];
  end

  // Only the highest-priority strobe acts; lower ones in the same cycle vanish silently.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      for (int k = 0; k < OPERANDS; k++) begin
        r_bin[k] <= '0;
        r_bcd[k] <= '0;
      end
      for (int k = 0; k < OPERANDS-1; k++)
        r_opc[k] <= '0;
      r_cur    <= '0;
      r_dc     <= '0;
      r_opcnt  <= '0;
      r_reject <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      if (r_state == S_READY) begin
        if (w_ready_key) r_reject <= 1'b1;
      end else if (clear_entry) begin
        r_bin[r_cur] <= '0;
        r_bcd[r_cur] <= '0;
        r_dc         <= '0;
      end else if (eq_valid) begin
        r_opcnt <= OCW'(r_cur) + OCW'(1);
      end else if (op_valid) begin
        if (r_cur < LAST_IDX) begin
          r_opc[r_cur] <= op_code;
          r_cur        <= r_cur + CIW'(1);
          r_dc         <= '0;
        end else begin
          r_reject <= 1'b1;
        end
      end else if (digit_valid) begin
        if (w_digit_bad) begin
          r_reject <= 1'b1;
        end else if (!w_lead_zero) begin
          r_bin[r_cur] <= w_bin_nxt;
          r_bcd[r_cur] <= w_bcd_nxt;
          r_dc         <= r_dc + DCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed key sequences then random keys, every cycle's outputs
// checked against a decimal-value model through an expected queue.
module tb_operand_entry;

  localparam int DIGITS   = 4;
  localparam int OPERANDS = 2;
  localparam int BIN_W    = 14;
  localparam int CIW      = (OPERANDS > 2) ? $clog2(OPERANDS) : 1;
  localparam int DCW      = $clog2(DIGITS+1);
  localparam int OCW      = $clog2(OPERANDS+1);
  localparam int W        = OPERANDS*BIN_W + OPERANDS*4*DIGITS + 2*(OPERANDS-1)
                            + CIW + DCW + OCW + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic digit_valid = 1'b0;
  logic [3:0] digit = '0;
  logic op_valid = 1'b0;
  logic [1:0] op_code = '0;
  logic eq_valid = 1'b0;
  logic clear_entry = 1'b0;
  logic clear_all = 1'b0;
  logic result_ack = 1'b0;
  logic [OPERANDS*BIN_W-1:0]    operands_bin;
  logic [OPERANDS*4*DIGITS-1:0] operands_bcd;
  logic [2*(OPERANDS-1)-1:0]    op_codes;
  logic [CIW-1:0]               cur_index;
  logic [DCW-1:0]               digit_count;
  logic [OCW-1:0]               operand_count;
  logic                         ready;
  logic                         reject;
  logic                         state_dbg;

  operand_entry #(.DIGITS(DIGITS), .OPERANDS(OPERANDS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .op_valid(op_valid), .op_code(op_code), .eq_valid(eq_valid),
    .clear_entry(clear_entry), .clear_all(clear_all), .result_ack(result_ack),
    .operands_bin(operands_bin), .operands_bcd(operands_bcd), .op_codes(op_codes),
    .cur_index(cur_index), .digit_count(digit_count), .operand_count(operand_count),
    .ready(ready), .reject(reject), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: operands held as plain decimal integers
  int m_val [OPERANDS];
  int m_opc [OPERANDS];
  int m_cur, m_dc, m_cnt, m_ready, m_rej;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_cyc = 0;

  task automatic model_clear();
    for (int k = 0; k < OPERANDS; k++) begin
      m_val[k] = 0;
      m_opc[k] = 0;
    end
    m_cur = 0; m_dc = 0; m_cnt = 0; m_ready = 0; m_rej = 0;
  endtask

  task automatic model_edge(input bit r, input bit ca, input bit ce, input bit eq,
                            input bit op, input int oc, input bit dv, input int d,
                            input bit ack);
    m_rej = 0;
    if (r || ca || (m_ready != 0 && ack)) model_clear();
    else if (m_ready != 0) begin
      if (ce || eq || op || dv) m_rej = 1;
    end else if (ce) begin
      m_val[m_cur] = 0; m_dc = 0;
    end else if (eq) begin
      m_cnt = m_cur + 1; m_ready = 1;
    end else if (op) begin
      if (m_cur < OPERANDS-1) begin
        m_opc[m_cur] = oc; m_cur++; m_dc = 0;
      end else m_rej = 1;
    end else if (dv) begin
      if (d > 9 || m_dc == DIGITS) m_rej = 1;
      else if (!(d == 0 && m_dc == 0)) begin
        m_val[m_cur] = m_val[m_cur]*10 + d; m_dc++;
      end
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    logic [OPERANDS*BIN_W-1:0]    b;
    logic [OPERANDS*4*DIGITS-1:0] c;
    logic [2*(OPERANDS-1)-1:0]    o;
    int v;
    b = '0; c = '0; o = '0;
    for (int k = 0; k < OPERANDS; k++) begin
      b[k*BIN_W +: BIN_W] = BIN_W'(m_val[k] % (1 << BIN_W));
      v = m_val[k];
      for (int i = 0; i < DIGITS; i++) begin
        c[k*4*DIGITS + 4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    for (int k = 0; k < OPERANDS-1; k++) o[2*k +: 2] = 2'(m_opc[k]);
    return {b, c, o, CIW'(m_cur), DCW'(m_dc), OCW'(m_cnt), 1'(m_ready), 1'(m_rej), 1'(m_ready)};
  endfunction

  // driver: inputs change on negedge, model advances at the posedge that samples them
  task automatic step(input bit r, input bit ca, input bit ce, input bit eq, input bit op,
                      input int oc, input bit dv, input int d, input bit ack);
    @(negedge clk);
    rst = r; clear_all = ca; clear_entry = ce; eq_valid = eq; op_valid = op;
    op_code = 2'(oc); digit_valid = dv; digit = 4'(d); result_ack = ack;
    @(posedge clk);
    model_edge(r, ca, ce, eq, op, oc, dv, d, ack);
    exp_q.push_back(model_vec());
  endtask

  task automatic key(input int d);  step(0,0,0,0,0,0,1,d,0); endtask
  task automatic opk(input int oc); step(0,0,0,0,1,oc,0,0,0); endtask
  task automatic idle();            step(0,0,0,0,0,0,0,0,0); endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    n_cyc++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {operands_bin, operands_bcd, op_codes, cur_index, digit_count,
             operand_count, ready, reject, state_dbg};
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL outputs cycle %0d: got %h required %h", n_cyc, act, e);
      end
    end
  end

  initial begin
    model_clear();
    step(1,0,0,0,0,0,0,0,0);
    step(1,0,0,0,0,0,0,0,0);
    // digit limit: fifth key rejected
    key(1); key(2); key(3); key(4); key(5); idle();
    // leading zeros suppressed
    step(0,1,0,0,0,0,0,0,0);
    key(0); key(0); key(7); idle();
    // full expression, present, acknowledge
    step(0,1,0,0,0,0,0,0,0);
    key(4); key(2); opk(1); key(9); step(0,0,0,1,0,0,0,0,0); idle();
    step(0,0,0,0,0,0,0,0,1); idle();
    // clear_entry, then operator overflow
    key(5); key(6); step(0,0,1,0,0,0,0,0,0); key(8); opk(2); opk(3); idle();
    // simultaneous digit and op, then key while ready
    step(0,1,0,0,0,0,0,0,0);
    step(0,0,0,0,1,2,1,3,0); step(0,0,0,1,0,0,0,0,0); key(1); idle();
    step(0,0,0,0,0,0,0,0,1);
    // invalid digit, ack in entry ignored
    key(12); step(0,0,0,0,0,0,0,0,1);
    // reset mid-entry
    key(9); key(9); step(1,0,0,0,0,0,0,0,0); key(1); idle();
    // random keys
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0,99) < 1, $urandom_range(0,99) < 3, $urandom_range(0,99) < 5,
           $urandom_range(0,99) < 8, $urandom_range(0,99) < 15, $urandom_range(0,3),
           $urandom_range(0,99) < 55, ($urandom_range(0,9) < 8) ? $urandom_range(0,9)
                                                                  : $urandom_range(10,15),
           $urandom_range(0,99) < 20);
    end
    idle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
# operand_entry

Parametrised keypad-operand accumulator for the calculator datapath. It collects decimal key digits into up to OPERANDS operands, separated by operator keys, and keeps each operand in binary and packed-BCD form. On the equals key it presents a complete, stable expression to the ALU/display stage with a ready/ack handshake. Compared with the fixed two-operand entry logic, it adds per-operand digit limits, leading-zero suppression, entry clear and all-clear, reject signalling and an explicit result handshake.

## Interface
- DIGITS, 4: maximum significant digits per operand (≥1).
- OPERANDS, 2: number of operands per expression (≥2).
- BIN_W, 14: binary width per operand. Must satisfy 2^BIN_W > 10^DIGITS−1.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- digit_valid  in  1  one-cycle key strobe carrying a digit.
- digit  in  4  digit value 0–9. Values 10–15 are rejected.
- op_valid  in  1  operator key strobe.
- op_code  in  2  operator code, stored verbatim.
- eq_valid  in  1  equals key strobe.
- clear_entry  in  1  clears the current operand only.
- clear_all  in  1  clears the whole expression.
- result_ack  in  1  consumer has taken the expression.
- operands_bin  out  OPERANDS*BIN_W  operand k at [k*BIN_W +: BIN_W].
- operands_bcd  out  OPERANDS*4*DIGITS  operand k at [k*4*DIGITS +: 4*DIGITS], with the least-significant digit in the low nibble.
- op_codes  out  2*(OPERANDS−1)  the operator between operand k and operand k+1, at [2k +: 2].
- cur_index  out  max(1,$clog2(OPERANDS))  operand currently being entered.
- digit_count  out  $clog2(DIGITS+1)  significant digits in the current operand.
- operand_count  out  $clog2(OPERANDS+1)  operands in the presented expression. Valid while ready is high.
- ready  out  1  the expression is complete and stable.
- reject  out  1  one-cycle pulse: the key was ignored.

## Operation
- Two states:
  - ENTRY (the reset state).
  - READY.
- Reset value of all outputs is 0. The FSM returns to ENTRY.
- Per-cycle event priority: rst > clear_all > clear_entry > eq_valid > op_valid > digit_valid. Only the highest-priority asserted event acts. Lower-priority strobes in the same cycle are dropped silently, with no reject.
- ENTRY, digit_valid:
  - digit > 9: reject.
  - digit_count == DIGITS: reject. The operand is unchanged.
  - digit == 0 and digit_count == 0: accepted as a no-op. The value stays 0 and the count stays 0 (leading-zero suppression).
  - Otherwise:
    - bin ← bin*10 + digit, truncated to BIN_W.
    - bcd ← {bcd[4*DIGITS−5:0], digit}.
    - digit_count increments.
- ENTRY, op_valid:
  - If cur_index < OPERANDS−1: op_codes[cur_index] ← op_code, cur_index increments, digit_count ← 0. An empty current operand counts as 0.
  - Else: reject.
- ENTRY, eq_valid: operand_count ← cur_index+1, ready ← 1, go to READY. Operands beyond cur_index remain 0.
- ENTRY, clear_entry: current operand bin/bcd ← 0 and digit_count ← 0. cur_index and op_codes are kept.
- clear_all, in any state: every operand, every op_code, cur_index, digit_count, operand_count and ready ← 0. Go to ENTRY.
- READY:
  - digit_valid, op_valid, eq_valid and clear_entry each produce reject. Nothing else changes.
  - result_ack: same clear as clear_all. Go to ENTRY.
  - result_ack while in ENTRY is ignored, with no reject.

## Timing
- Every accepted event updates the outputs on the clock edge that samples it. The new value is visible the following cycle (latency 1).
- reject pulses in the cycle after the offending strobe, for exactly one cycle.
- ready rises 1 cycle after eq_valid. It stays high, with every output frozen, until the cycle after result_ack or clear_all.
- A new expression may begin on the cycle after ready falls. Back-to-back strobes on consecutive cycles are each accepted.
- rst asserted mid-entry or in READY clears everything at the next edge, regardless of other inputs.

## Test plan
- DIGITS=4: keys 1,2,3,4,5 -> operand0 bin 1234, bcd 0x1234, digit_count 4; the fifth key produces a reject pulse.
- Keys 0,0,7 -> operand0 bin 7, bcd 0x0007, digit_count 1.
- Keys 4,2, op 2'b01, 9, eq -> ready=1, operands_bin {9,42}, op_codes 2'b01, operand_count 2; result_ack -> all outputs 0 the next cycle.
- Keys 5,6, clear_entry, 8, op, op -> operand0 = 8; the second op is rejected (OPERANDS=2); cur_index = 1.
- digit_valid and op_valid asserted in the same cycle with digit 3 -> only the op is taken, operand0 is unchanged, and no reject is produced. In READY, digit 1 -> reject with outputs frozen.
- rst pulsed after keys 9,9 -> all outputs 0 the next cycle; a subsequent key 1 gives operand0 = 1.
